// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: FSM encoding,
// minimum divisor and the high-phase length helper.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MIN_DIV = 2;

    // ceil(n/2): odd divisors put the extra cycle in the high phase
    function automatic logic [31:0] ceil_half(input logic [31:0] n);
        return (n + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Modulo-N phase counter; holds at zero while the divider is not running.
module clk_div_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] cnt_next,
    output logic             wrap
);

    assign wrap     = run && (cnt == n - WIDTH'(1));
    assign cnt_next = wrap ? '0 : cnt + WIDTH'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (run)
            cnt <= cnt_next;
        else
            cnt <= '0;
    end

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider; divisor and enable changes
// only land on period boundaries so out_clk never produces a runt pulse.
module clk_divider_prog
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             load,
    output logic             out_clk,
    output logic             tick,
    output logic [WIDTH-1:0] div_active,
    output logic             upd_pending
);

    state_t           state, state_nx;
    logic [WIDTH-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] div_clamped;
    logic [WIDTH-1:0] h;
    logic             wrap;
    logic             go;
    logic             apply;

    clk_div_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .run      (state == RUN),
        .n        (div_active),
        .cnt      (cnt),
        .cnt_next (cnt_next),
        .wrap     (wrap)
    );

    assign div_clamped = (div_val < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : div_val;
    // At a boundary cnt_next is 0, which is below H for any N, so the
    // current divisor's H is always the right one to compare against.
    assign h     = WIDTH'(ceil_half(32'(div_active)));
    assign go    = (state == IDLE) && en;
    assign apply = go || wrap;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en) state_nx = RUN;
            RUN:     if (wrap && !en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            out_clk     <= 1'b0;
            tick        <= 1'b0;
            div_active  <= WIDTH'(DEFAULT_DIV);
            pending     <= '0;
            upd_pending <= 1'b0;
        end else begin
            state <= state_nx;

            // A load landing on an apply point bypasses the pending register
            if (load && apply) begin
                div_active  <= div_clamped;
                upd_pending <= 1'b0;
            end else if (load) begin
                pending     <= div_clamped;
                upd_pending <= 1'b1;
            end else if (apply && upd_pending) begin
                div_active  <= pending;
                upd_pending <= 1'b0;
            end

            if (state_nx == RUN) begin
                out_clk <= go || (cnt_next < h);
                tick    <= go || (cnt_next == '0);
            end else begin
                out_clk <= 1'b0;
                tick    <= 1'b0;
            end
        end
    end

endmodule
